// File: rtl/logic_tree_sequencer.sv
// logic_tree_sequencer
//   Time-multiplexed evaluator for y = ((a & b) & (c & d)) | (e & f).
//   A single shared 2-input bitwise gate and two scratch registers (s0, s1)
//   replace five parallel gates. One gate operation is done per EVAL cycle,
//   so every evaluation takes exactly five EVAL cycles.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   in_valid         operand set valid (input side)
//   in_ready         sequencer can accept an operand set
//   a..f             operands, captured on the input handshake
//   out_valid        result valid (output side)
//   out_ready        consumer accepts the result
//   y                result, held until the output handshake
//   busy             high while evaluating
//   step             current gate op index (0-4), 0 outside EVAL
//   eval_count       completed output handshakes, wraps modulo 2^CNT_W

module logic_tree_sequencer #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] f,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             busy,
   output logic [2:0]       step,
   output logic [CNT_W-1:0] eval_count
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StEval = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [2:0]       step_q, step_d;
   logic [WIDTH-1:0] a_q, b_q, c_q, d_q, e_q, f_q;
   logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic             out_hs;
   logic [WIDTH-1:0] op_x, op_y, gate_out;
   logic             op_or;

   assign in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
   assign accept   = in_valid & in_ready;
   assign out_hs   = (state_q == StDone) & out_ready;

   // Shared gate unit: operand mux and AND/OR select driven by the step index.
   always_comb begin
      op_x  = '0;
      op_y  = '0;
      op_or = 1'b0;
      unique case (step_q)
         3'd0: begin
            op_x = a_q;
            op_y = b_q;
         end
         3'd1: begin
            op_x = c_q;
            op_y = d_q;
         end
         3'd2: begin
            op_x = s0_q;
            op_y = s1_q;
         end
         3'd3: begin
            op_x = e_q;
            op_y = f_q;
         end
         default: begin
            op_x  = s0_q;
            op_y  = s1_q;
            op_or = 1'b1;
         end
      endcase
      gate_out = op_or ? (op_x | op_y) : (op_x & op_y);
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StEval;
               step_d  = 3'd0;
            end
         end
         StEval: begin
            unique case (step_q)
               3'd0, 3'd2: s0_d = gate_out;
               3'd1, 3'd3: s1_d = gate_out;
               default:    y_d  = gate_out;
            endcase
            if (step_q < 3'd4) begin
               step_d = step_q + 3'd1;
            end else begin
               step_d  = 3'd0;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_hs) begin
               cnt_d = cnt_q + 1'b1;
               // Back-to-back: a pending operand set goes straight to EVAL.
               state_d = in_valid ? StEval : StIdle;
               step_d  = 3'd0;
            end
         end
         default: begin
            state_d = StIdle;
            step_d  = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         step_q  <= 3'd0;
         s0_q    <= '0;
         s1_q    <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
      end
   end

   // Operands are captured only on the input handshake and held through EVAL/DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         d_q <= '0;
         e_q <= '0;
         f_q <= '0;
      end else if (accept) begin
         a_q <= a;
         b_q <= b;
         c_q <= c;
         d_q <= d;
         e_q <= e;
         f_q <= f;
      end
   end

   assign out_valid  = (state_q == StDone);
   assign busy       = (state_q == StEval);
   assign step       = busy ? step_q : 3'd0;
   assign y          = y_q;
   assign eval_count = cnt_q;

endmodule

// File: doc/logic_tree_sequencer.md
Name: logic_tree_sequencer

Overview:
- Time-multiplexed evaluator for the asymmetric reduction tree y = ((a & b) & (c & d)) | (e & f).
- Uses one shared 2-input bitwise gate unit and a small scratch register file instead of five parallel gates.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Serves as the area-reduced alternative to the flat combinational tree.

Parameters:
- WIDTH, 1, bit-width of each operand and of the result (bitwise lanes, evaluated in parallel).
- CNT_W, 8, width of the completed-evaluation counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  sequencer can accept an operand set
- a, b, c, d, e, f  input  WIDTH each  operands, sampled on input handshake
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  result
- busy  output  1  high while in EVAL
- step  output  3  current op index (0-4), 0 outside EVAL
- eval_count  output  CNT_W  number of completed output handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, immediate):
  - state=IDLE; in_ready=1; out_valid=0; y=0; busy=0; step=0; eval_count=0.
  - Operand and scratch registers cleared to 0.
  - Reset mid-EVAL or mid-DONE discards the evaluation; no output is produced for it.
- Input handshake when in_valid & in_ready at a rising edge:
  - Capture a..f into operand registers.
  - Enter EVAL with step=0.
  - Operands are never re-sampled during EVAL/DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from state and out_ready; no in_valid→in_ready path.
- States: IDLE, EVAL, DONE.
- EVAL executes one op per cycle through the single gate unit (op select AND/OR):
  - step 0: s0 <= a & b
  - step 1: s1 <= c & d
  - step 2: s0 <= s0 & s1
  - step 3: s1 <= e & f
  - step 4: y <= s0 | s1; go to DONE
  - Steps 0-3 increment step; busy=1 throughout EVAL.
- Latency: accept at edge k -> out_valid rises after edge k+5. Exactly five EVAL cycles, independent of operand values (no short-circuit).
- DONE:
  - out_valid=1; y held stable until out_valid & out_ready.
  - On output handshake, eval_count increments (wraps at all-ones -> 0).
  - If in_valid is also high on that edge (back-to-back): capture the new operands and go directly to EVAL step 0. out_valid falls; no IDLE bubble.
  - If in_valid is low on that edge: go to IDLE; out_valid=0; y retains its last value.
- out_valid never drops without a handshake except on rst.
- Throughput: one result per 6 cycles with a continuously ready consumer and continuous input.
- in_valid during EVAL is ignored (in_ready=0); the producer must hold its data.

Test Plan:
- Reset release, idle inputs -> in_ready=1, out_valid=0, y=0, eval_count=0, busy=0.
- WIDTH=4, a=5 b=F c=7 d=E e=1 f=2, out_ready=1 -> intermediates s0=5, s1=6, s0=4, s1=0; out_valid after edge k+5 with y=4; eval_count=1.
- WIDTH=4, a=F b=F c=F d=3 e=C f=A -> y=B.
- Operands all 0 except e=f=F -> y=F; then change a..f during EVAL -> result unaffected.
- Back-to-back with out_ready=1 and in_valid held high on two operand sets -> second accept coincides with first output handshake; results 6 cycles apart, no IDLE cycle.
- out_ready=0 for 10 cycles in DONE -> y and out_valid stable, in_ready=0.
- Assert rst at EVAL step 2 -> immediate return to reset values, no output.
- 256 evaluations with CNT_W=8 -> eval_count wraps to 0.
